// File: rtl/specreg_pkg.sv
// rtl/specreg_pkg.sv - flag bit positions, condition codes and flags type shared by specreg_unit and the branch unit
package specreg_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/condition_evaluator.sv
// rtl/condition_evaluator.sv - combinational condition-code check of a {N,Z,C,V} flag set
module condition_evaluator
    import specreg_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] condition,
    output logic       condition_met
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condition_met = 1'b0;
        case (condition)
            COND_EQ: condition_met = z;
            COND_NE: condition_met = !z;
            COND_CS: condition_met = c;
            COND_CC: condition_met = !c;
            COND_MI: condition_met = n;
            COND_PL: condition_met = !n;
            COND_VS: condition_met = v;
            COND_VC: condition_met = !v;
            COND_HI: condition_met = c && !z;
            COND_LS: condition_met = !c || z;
            COND_GE: condition_met = (n == v);
            COND_LT: condition_met = (n != v);
            COND_GT: condition_met = !z && (n == v);
            COND_LE: condition_met = z || (n != v);
            COND_AL: condition_met = 1'b1;
            COND_NV: condition_met = 1'b0;
            default: condition_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/specreg_unit.sv
// rtl/specreg_unit.sv - status register, carry feedback, condition check and interrupt flag stack (SPECREG_BYPASS_EN forwards ALU flags)
module specreg_unit
    import specreg_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Negative_ALU_flag,
    input  logic       Zero_ALU_flag,
    input  logic       Carry_ALU_flag,
    input  logic       oVerflow_ALU_flag,
    input  logic       flag_write_enable,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] condition,
    output logic [3:0] specreg,
    output logic       previous_specreg_carry,
    output logic       condition_met,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_error
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    flags_t                 specreg_q;
    flags_t                 slots [STACK_DEPTH];
    logic [DEPTH_WIDTH-1:0] occupancy;
    logic                   error_q;

    flags_t                 alu_flags;
    flags_t                 eval_flags;
    logic                   push_only, pop_only;
    logic                   do_push, do_pop, error_d;
    logic [IDX_W-1:0]       push_idx, pop_idx;

    assign alu_flags = {Negative_ALU_flag, Zero_ALU_flag, Carry_ALU_flag, oVerflow_ALU_flag};

    assign stack_empty = (occupancy == '0);
    assign stack_full  = (occupancy == DEPTH_WIDTH'(STACK_DEPTH));

    // Simultaneous push and pop cancel out: no stack change and no error.
    assign push_only = push && !pop;
    assign pop_only  = pop && !push;
    assign do_push   = push_only && !stack_full;
    assign do_pop    = pop_only && !stack_empty;
    assign error_d   = (push_only && stack_full) || (pop_only && stack_empty);

    assign push_idx = IDX_W'(occupancy);
    assign pop_idx  = IDX_W'(occupancy - DEPTH_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            specreg_q <= '0;
            occupancy <= '0;
            error_q   <= 1'b0;
        end else begin
            error_q <= error_d;
            if (do_pop) begin
                specreg_q <= slots[pop_idx];
                occupancy <= occupancy - DEPTH_WIDTH'(1);
            end else begin
                if (flag_write_enable) begin
                    specreg_q <= alu_flags;
                end
                if (do_push) begin
                    slots[push_idx] <= specreg_q;
                    occupancy       <= occupancy + DEPTH_WIDTH'(1);
                end
            end
        end
    end

`ifdef SPECREG_BYPASS_EN
    assign eval_flags = (flag_write_enable && !pop) ? alu_flags : specreg_q;
`else
    assign eval_flags = specreg_q;
`endif

    assign specreg                = specreg_q;
    assign previous_specreg_carry = eval_flags[FLAG_C];
    assign stack_error            = error_q;

    condition_evaluator u_condition_evaluator (
        .flags         (eval_flags),
        .condition     (condition),
        .condition_met (condition_met)
    );

endmodule

// File: tb/tb_specreg_unit.sv
// tb/tb_specreg_unit.sv - randomized and directed scoreboard bench for specreg_unit
module tb_specreg_unit;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       n_in, z_in, c_in, v_in;
    logic       flag_write_enable, push, pop;
    logic [3:0] condition;
    logic [3:0] specreg;
    logic       previous_specreg_carry, condition_met;
    logic       stack_empty, stack_full, stack_error;

    specreg_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .Negative_ALU_flag      (n_in),
        .Zero_ALU_flag          (z_in),
        .Carry_ALU_flag         (c_in),
        .oVerflow_ALU_flag      (v_in),
        .flag_write_enable      (flag_write_enable),
        .push                   (push),
        .pop                    (pop),
        .condition              (condition),
        .specreg                (specreg),
        .previous_specreg_carry (previous_specreg_carry),
        .condition_met          (condition_met),
        .stack_empty            (stack_empty),
        .stack_full             (stack_full),
        .stack_error            (stack_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] spec;
        logic       empty;
        logic       full;
        logic       err;
        logic       met;
        logic       carry;
    } exp_t;

    exp_t       exp_q [$];
    logic [3:0] m_spec;
    logic [3:0] m_stack [$];
    logic       m_err;
    int         vectors = 0;
    int         miscompares = 0;
    bit         done = 0;

    function automatic logic cond_ref(logic [3:0] f, logic [3:0] cc);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
        end
    endtask

    // One cycle: drive inputs after the edge, record what the DUT must show this cycle, advance the model.
    task automatic step(input logic rst, input logic fwe, input logic [3:0] alu,
                        input logic ps, input logic pp, input logic [3:0] cc);
        exp_t       e;
        logic [3:0] f;
        logic [3:0] nxt;
        @(posedge clock);
        #2;
        reset = rst; flag_write_enable = fwe; {n_in, z_in, c_in, v_in} = alu;
        push = ps; pop = pp; condition = cc;
        f = m_spec;
`ifdef SPECREG_BYPASS_EN
        if (fwe && !pp) f = alu;
`endif
        e.spec  = m_spec;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == DEPTH);
        e.err   = m_err;
        e.met   = cond_ref(f, cc);
        e.carry = f[1];
        exp_q.push_back(e);
        if (rst) begin
            m_spec = 4'h0;
            m_stack.delete();
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            nxt = fwe ? alu : m_spec;
            if (ps && !pp) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_spec);
            end
            if (pp && !ps) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else nxt = m_stack.pop_back();
            end
            m_spec = nxt;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #4;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("specreg", specreg, e.spec);
                chk("stack_empty", {3'b0, stack_empty}, {3'b0, e.empty});
                chk("stack_full", {3'b0, stack_full}, {3'b0, e.full});
                chk("stack_error", {3'b0, stack_error}, {3'b0, e.err});
                chk("condition_met", {3'b0, condition_met}, {3'b0, e.met});
                chk("carry", {3'b0, previous_specreg_carry}, {3'b0, e.carry});
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; flag_write_enable = 0; push = 0; pop = 0;
        {n_in, z_in, c_in, v_in} = 4'h0; condition = 4'h0;
        m_spec = 4'h0; m_err = 1'b0;
        repeat (2) @(posedge clock);

        step(1, 0, 4'h0, 0, 0, 4'd0);
        step(0, 1, 4'b0110, 0, 0, 4'd0);
        step(0, 0, 4'h0, 0, 0, 4'd0);
        step(0, 0, 4'h0, 0, 0, 4'd8);

        for (int s = 0; s < 16; s++) begin
            step(0, 1, 4'(s), 0, 0, 4'd14);
            for (int c = 0; c < 16; c++) step(0, 0, 4'h0, 0, 0, 4'(c));
        end

        step(0, 1, 4'b0010, 0, 0, 4'd2);
        step(0, 1, 4'b1100, 1, 0, 4'd2);
        step(0, 1, 4'b0001, 0, 1, 4'd6);
        step(0, 0, 4'h0, 0, 0, 4'd6);

        for (int i = 0; i < 5; i++) step(0, 1, 4'(i + 3), 1, 0, 4'(i));
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 0, 1, 4'(i + 8));
        step(0, 0, 4'h0, 0, 0, 4'd0);

        step(0, 1, 4'b1010, 1, 0, 4'd10);
        step(0, 1, 4'b0101, 1, 0, 4'd11);
        step(0, 1, 4'b1111, 1, 1, 4'd12);
        step(0, 0, 4'h0, 1, 0, 4'd13);
        step(1, 1, 4'b1011, 1, 0, 4'd1);
        step(0, 0, 4'h0, 0, 0, 4'd0);

        step(0, 1, 4'b0000, 0, 0, 4'd3);
        step(0, 1, 4'b0010, 0, 0, 4'd3);

        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step((r < 2), 1'($urandom), 4'($urandom), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 30), 4'($urandom));
        end
        step(0, 0, 4'h0, 0, 0, 4'd14);
        @(posedge clock);
        #6;
        done = 1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation time limit reached, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
